// File: rtl/free_vec_allocn.sv
// free_vec_allocn
//   Registered free-entry bitmask that offers up to N free entries per cycle,
//   lowest index first.  Accepted grants are retired from the mask on the
//   next clock edge, and returned entries (dealloc_vec) are OR'ed back in.
//
// Ports
//   CLK                 rising-edge clock
//   RST                 asynchronous active-high reset (loads INIT_FREE)
//   alloc_valid_by_n    lane n has a free entry to offer
//   alloc_one_hot_by_n  one-hot of the lane n entry (zero if lane invalid)
//   alloc_index_by_n    binary index of the lane n entry (zero if lane invalid)
//   alloc_ready_by_n    consumer accepts lane n (in-order: lane n needs lane n-1)
//   dealloc_vec         entries returned to the pool this cycle
//   free_count          registered popcount of the free mask
//   empty / full        free mask all zeros / all ones
//   dealloc_conflict    combinational: a returned entry is already free
module free_vec_allocn #(
  parameter int unsigned          WIDTH     = 8,
  parameter int unsigned          N         = 3,
  parameter logic [WIDTH-1:0]     INIT_FREE = '1
) (
  input  logic                                                   CLK,
  input  logic                                                   RST,
  output logic [N-1:0]                                           alloc_valid_by_n,
  output logic [N-1:0][WIDTH-1:0]                                alloc_one_hot_by_n,
  output logic [N-1:0][((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0]    alloc_index_by_n,
  input  logic [N-1:0]                                           alloc_ready_by_n,
  input  logic [WIDTH-1:0]                                       dealloc_vec,
  output logic [$clog2(WIDTH+1)-1:0]                             free_count,
  output logic                                                   empty,
  output logic                                                   full,
  output logic                                                   dealloc_conflict
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CW = $clog2(WIDTH+1);

  function automatic logic [CW-1:0] popcnt(input logic [WIDTH-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  localparam logic [CW-1:0] INIT_COUNT = popcnt(INIT_FREE);

  logic [WIDTH-1:0]        free_mask_q, free_mask_d;
  logic [CW-1:0]           free_count_q, free_count_d;

  logic [N-1:0]            lane_valid;
  logic [N-1:0][WIDTH-1:0] lane_oh;
  logic [N-1:0][IW-1:0]    lane_idx;
  logic [WIDTH-1:0]        remaining;
  logic [WIDTH-1:0]        taken_mask;
  logic                    chain;

  // Each lane picks the lowest bit still set after removing the entries
  // claimed by lower lanes, so lanes can never offer the same entry.
  always_comb begin
    remaining  = free_mask_q;
    lane_valid = '0;
    lane_oh    = '0;
    lane_idx   = '0;
    for (int unsigned n = 0; n < N; n++) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (!lane_valid[n] && remaining[i]) begin
          lane_valid[n] = 1'b1;
          lane_oh[n][i] = 1'b1;
          lane_idx[n]   = IW'(i);
        end
      end
      remaining = remaining & ~lane_oh[n];
    end
  end

  // In-order acceptance: once a lane is not taken, no higher lane is.
  always_comb begin
    chain      = 1'b1;
    taken_mask = '0;
    for (int unsigned n = 0; n < N; n++) begin
      chain = chain & lane_valid[n] & alloc_ready_by_n[n];
      if (chain) begin
        taken_mask = taken_mask | lane_oh[n];
      end
    end
    free_mask_d  = (free_mask_q & ~taken_mask) | dealloc_vec;
    free_count_d = popcnt(free_mask_d);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      free_mask_q  <= INIT_FREE;
      free_count_q <= INIT_COUNT;
    end else begin
      free_mask_q  <= free_mask_d;
      free_count_q <= free_count_d;
    end
  end

  always_comb begin
    alloc_valid_by_n   = lane_valid;
    alloc_one_hot_by_n = lane_oh;
    alloc_index_by_n   = lane_idx;
    free_count         = free_count_q;
    empty              = (free_mask_q == '0);
    full               = (free_mask_q == '1);
    dealloc_conflict   = |(dealloc_vec & free_mask_q);
  end

endmodule

// File: doc/free_vec_allocn.md
Name: free_vec_allocN

Overview:
- Registered free-entry bitmask with up to N allocations per cycle, LSB-first.
- It is the consumer/state side of the N-way LSB priority select. It holds the request vector, presents the first N free entries as one-hot and index grants, and retires accepted grants from its own state.
- Used for free-list and issue-slot allocation (physical registers, LSQ/ROB slots) feeding rename and dispatch.
- Deallocations return entries to the pool.

Parameters:
- WIDTH, 8, number of tracked entries.
- N, 3, allocation lanes per cycle (N <= WIDTH).
- INIT_FREE, all ones (WIDTH bits), free mask loaded on reset.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous active-high reset.
- alloc_valid_by_n  output  N  lane n has a free entry to offer.
- alloc_one_hot_by_n  output  N x WIDTH  one-hot of the entry offered on lane n; zero if lane invalid.
- alloc_index_by_n  output  N x $clog2(WIDTH)  binary index of the lane n entry; zero if lane invalid.
- alloc_ready_by_n  input  N  consumer accepts lane n this cycle.
- dealloc_vec  input  WIDTH  entries returned to the pool this cycle; any number of bits.
- free_count  output  $clog2(WIDTH+1)  registered popcount of the free mask.
- empty  output  1  free mask == 0.
- full  output  1  free mask == all ones.
- dealloc_conflict  output  1  combinational; (dealloc_vec & free_mask) != 0.

Behaviour:
- State: free_mask[WIDTH-1:0] and free_count, both registered.
  - Async reset: free_mask = INIT_FREE, free_count = popcount(INIT_FREE).
  - RST asserted mid-operation discards all in-flight grants and deallocs immediately.
- Lane offers, combinational from free_mask only (no dealloc bypass):
  - lane n offers the (n+1)-th lowest set bit of free_mask.
  - alloc_valid_by_n[n] = popcount(free_mask) > n.
  - Lanes never offer the same entry.
- Reset values of outputs:
  - alloc_valid = lowest min(N, popcount(INIT_FREE)) bits set.
  - one-hot and index per the rule above.
  - empty = (INIT_FREE == 0), full = (INIT_FREE == all ones), dealloc_conflict driven only by the input.
- Handshake, in order:
  - taken[n] = alloc_valid_by_n[n] & alloc_ready_by_n[n] & taken[n-1], with taken[-1] = 1.
  - Ready on a higher lane while a lower lane is not taken is ignored; that entry stays free.
  - Ready on an invalid lane is ignored.
  - taken_mask = OR of alloc_one_hot_by_n[n] over all taken lanes.
- Next state: free_mask' = (free_mask & ~taken_mask) | dealloc_vec; free_count' = popcount(free_mask').
- Latency:
  - Accepted entries disappear from offers on the next cycle.
  - Deallocated entries become offerable on the next cycle.
  - No same-cycle reuse.
- Dealloc of an already-free entry:
  - dealloc_conflict = 1 in that cycle.
  - The entry stays free (OR semantics); no count corruption.
- Dealloc of an entry taken the same cycle is legal only through the conflict path (it is free at that point); the entry ends free.
- Empty: all alloc_valid = 0; ready is ignored; dealloc refills the mask next cycle.
- Full: all offers valid while WIDTH >= N; any dealloc in this state raises conflict.
- Fewer than N free entries: upper lanes are invalid, with zero one-hot and zero index.
- free_count saturates naturally at WIDTH; no wrap-around is possible.

Test Plan (WIDTH=8, N=3, INIT_FREE=8'hFF):
- RST=1 pulsed mid-run with free_mask=0x30 -> immediately free_mask=0xFF, alloc_valid=3'b111, one-hots {0x04,0x02,0x01}, indices {2,1,0}, free_count=8, full=1.
- From reset, ready=3'b111 for one cycle -> next cycle one-hots {0x20,0x10,0x08}, free_count=5, full=0.
- free_mask=0xFF, ready=3'b101 -> only lane 0 taken; next free_mask=0xFE, lane 0 offers 0x02, count=7.
- free_mask=0x80 -> alloc_valid=3'b001, lane 0 one-hot 0x80, index 7, lanes 1-2 zero. Ready=3'b111 -> next free_mask=0x00, empty=1, alloc_valid=000, free_count=0.
- free_mask=0x00, dealloc_vec=0x5A -> same cycle alloc_valid=000, conflict=0. Next cycle one-hots {0x10,0x08,0x02}, free_count=4.
- free_mask=0x0F, ready=3'b000, dealloc_vec=0x11 -> dealloc_conflict=1 that cycle; next free_mask=0x1F, free_count=5.
- Enumerate all 256 free_mask values (built via reset plus allocate/dealloc) -> offers equal the first three set bits LSB-first. Random ready/dealloc traffic against a reference mask model shows no mismatch.
